// File: rtl/alu_pkg.sv
// Shared definitions for alu and alu_share_arb: select encodings, FSM states, requester ID.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1010;
  localparam logic [3:0] ALU_SLT  = 4'b1100;
  localparam logic [3:0] ALU_SLTU = 4'b1110;

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  typedef logic req_id_t;

  function automatic logic sel_legal(input logic [3:0] sel);
    case (sel)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
      ALU_SLL, ALU_SRL, ALU_SLT, ALU_SLTU: sel_legal = 1'b1;
      default:                             sel_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU. SUB carry is the no-borrow carry out of a + ~b + 1;
// logic, shift and compare ops clear carry/overflow. Unknown selects give result 0.
module alu
  import alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  sel,
  output logic [31:0] result,
  output logic        carry,
  output logic        overflow,
  output logic        zero
);

  logic [32:0] sum;

  always_comb begin
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    sum      = '0;
    case (sel)
      ALU_ADD: begin
        sum      = {1'b0, a} + {1'b0, b};
        result   = sum[31:0];
        carry    = sum[32];
        overflow = (a[31] == b[31]) && (result[31] != a[31]);
      end
      ALU_SUB: begin
        sum      = {1'b0, a} + {1'b0, ~b} + 33'd1;
        result   = sum[31:0];
        carry    = sum[32];
        overflow = (a[31] != b[31]) && (result[31] != a[31]);
      end
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLL:  result = a << b[4:0];
      ALU_SRL:  result = a >> b[4:0];
      ALU_SLT:  result = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: result = {31'd0, a < b};
      default:  result = '0;
    endcase
    zero = (result == 32'd0);
  end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin share of one alu between two valid/ready requesters with a one-entry
// tagged response register. Optional illegal-select check: ALU_ILLEGAL_CHK_EN.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SEL_W   = 4,
  parameter bit          RR_INIT = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [SEL_W-1:0]  req0_sel,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [SEL_W-1:0]  req1_sel,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_carry,
  output logic              rsp_overflow,
  output logic              rsp_zero,
  output logic              rsp_err
);

  state_t  state_q, state_d;
  req_id_t last_grant_q;
  req_id_t winner;
  logic    can_accept;
  logic    accept;

  logic [DATA_W-1:0] alu_a, alu_b, alu_result;
  logic [SEL_W-1:0]  alu_sel;
  logic              alu_carry, alu_overflow, alu_zero;

  logic [DATA_W-1:0] result_d;
  logic              carry_d, overflow_d, zero_d;

  // Arbitration: a lone requester always wins; on contention the one not granted last wins.
  always_comb begin
    case (req_valid)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_grant_q;
      default: winner = 1'b0;
    endcase
    can_accept = (state_q == IDLE) | rsp_ready;
    accept     = can_accept & (|req_valid);
    req_ready  = 2'b00;
    if (accept) begin
      req_ready = winner ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    alu_a   = winner ? req1_a   : req0_a;
    alu_b   = winner ? req1_b   : req0_b;
    alu_sel = winner ? req1_sel : req0_sel;
  end

  alu u_alu (
    .a        (alu_a),
    .b        (alu_b),
    .sel      (alu_sel),
    .result   (alu_result),
    .carry    (alu_carry),
    .overflow (alu_overflow),
    .zero     (alu_zero)
  );

`ifdef ALU_ILLEGAL_CHK_EN
  logic err_d, err_q;

  always_comb begin
    result_d   = alu_result;
    carry_d    = alu_carry;
    overflow_d = alu_overflow;
    zero_d     = alu_zero;
    err_d      = 1'b0;
    if (!sel_legal(alu_sel)) begin
      result_d   = '0;
      carry_d    = 1'b0;
      overflow_d = 1'b0;
      zero_d     = 1'b1;
      err_d      = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= err_d;
    end
  end

  assign rsp_err = err_q;
`else
  always_comb begin
    result_d   = alu_result;
    carry_d    = alu_carry;
    overflow_d = alu_overflow;
    zero_d     = alu_zero;
  end

  assign rsp_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = HOLD;
      end
      HOLD: begin
        if (accept)         state_d = HOLD;
        else if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Data registers load only on accept; draining to IDLE leaves the old values in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= req_id_t'(RR_INIT);
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_carry    <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_zero     <= 1'b0;
    end else if (accept) begin
      last_grant_q <= winner;
      rsp_id       <= winner;
      rsp_result   <= result_d;
      rsp_carry    <= carry_d;
      rsp_overflow <= overflow_d;
      rsp_zero     <= zero_d;
    end
  end

  assign rsp_valid = (state_q == HOLD);

endmodule

// File: tb/tb_alu_share_arb.sv
// Scoreboard bench for alu_share_arb: expected responses are queued at accept and
// compared when the consumer takes them, plus directed handshake checks.
module tb_alu_share_arb;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_sel, req1_sel;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_carry, rsp_overflow, rsp_zero, rsp_err;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic        id;
    logic [31:0] result;
    logic        carry;
    logic        overflow;
    logic        zero;
    logic        err;
  } exp_t;

  exp_t sb_q[$];

  alu_share_arb dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req0_sel     (req0_sel),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .req1_sel     (req1_sel),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_carry    (rsp_carry),
    .rsp_overflow (rsp_overflow),
    .rsp_zero     (rsp_zero),
    .rsp_err      (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic id, input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] sel);
    exp_t        e;
    logic [32:0] w;
    e    = '0;
    e.id = id;
    case (sel)
      4'b0000: begin
        w          = {1'b0, a} + {1'b0, b};
        e.result   = w[31:0];
        e.carry    = w[32];
        e.overflow = (a[31] == b[31]) && (e.result[31] != a[31]);
      end
      4'b0001: begin
        e.result   = a - b;
        e.carry    = (a >= b);
        e.overflow = (a[31] != b[31]) && (e.result[31] != a[31]);
      end
      4'b0010: e.result = a & b;
      4'b0100: e.result = a | b;
      4'b0110: e.result = a ^ b;
      4'b1000: e.result = a << b[4:0];
      4'b1010: e.result = a >> b[4:0];
      4'b1100: e.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1110: e.result = (a < b) ? 32'd1 : 32'd0;
      default: begin
        e.result = 32'd0;
`ifdef ALU_ILLEGAL_CHK_EN
        e.err = 1'b1;
`endif
      end
    endcase
    e.zero = (e.result == 32'd0);
    return e;
  endfunction

  // Pop before push: a response consumed this cycle precedes the one accepted this cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb_q.delete();
    end else begin
      if (rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          chk("rsp_id", {63'd0, rsp_id}, {63'd0, e.id});
          chk("rsp_result", {32'd0, rsp_result}, {32'd0, e.result});
          chk("rsp_carry", {63'd0, rsp_carry}, {63'd0, e.carry});
          chk("rsp_overflow", {63'd0, rsp_overflow}, {63'd0, e.overflow});
          chk("rsp_zero", {63'd0, rsp_zero}, {63'd0, e.zero});
          chk("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
        end
      end
      if (req_ready != 2'b00) begin
        chk("ready_onehot", {62'd0, req_ready == 2'b11}, 64'd0);
        if (req_ready[1]) sb_q.push_back(model(1'b1, req1_a, req1_b, req1_sel));
        else              sb_q.push_back(model(1'b0, req0_a, req0_b, req0_sel));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel);
    req0_a = a; req0_b = b; req0_sel = sel;
  endtask

  task automatic drive1(input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel);
    req1_a = a; req1_b = b; req1_sel = sel;
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask

  logic [31:0] t4_b[4];
  logic [31:0] t4_a[4];
  logic [3:0]  t4_sel[4];
  logic [31:0] t4_exp[4];

  initial begin
    int waited;
    rst = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    drive0(32'd0, 32'd0, 4'd0);
    drive1(32'd0, 32'd0, 4'd0);
    tick;

    // Reset state
    chk("reset_valid", {63'd0, rsp_valid}, 64'd0);
    chk("reset_id", {63'd0, rsp_id}, 64'd0);
    chk("reset_result", {32'd0, rsp_result}, 64'd0);
    chk("reset_flags", {61'd0, rsp_carry, rsp_overflow, rsp_zero}, 64'd0);
    chk("reset_err", {63'd0, rsp_err}, 64'd0);
    chk("reset_ready", {62'd0, req_ready}, 64'd0);
    tick;
    rst = 1'b0;

    // 1: single requester, same-cycle ready, one-cycle latency
    rsp_ready = 1'b1;
    req_valid = 2'b01;
    drive0(32'd4, 32'd4, 4'b0000);
    #1 chk("t1_ready", {62'd0, req_ready}, 64'd1);
    tick;
    req_valid = 2'b00;
    chk("t1_valid", {63'd0, rsp_valid}, 64'd1);
    chk("t1_result", {32'd0, rsp_result}, 64'd8);
    chk("t1_zero", {63'd0, rsp_zero}, 64'd0);
    tick;

    // 2: contention after reset alternates starting with req0
    apply_reset;
    rsp_ready = 1'b1;
    drive0(32'hffff_fffe, 32'h0000_0001, 4'b0001);
    drive1(32'hffff_ffff, 32'h0000_0001, 4'b0000);
    req_valid = 2'b11;
    #1 chk("t2_ready0", {62'd0, req_ready}, 64'd1);
    tick;
    chk("t2_res0", {32'd0, rsp_result}, {32'd0, 32'hffff_fffd});
    #1 chk("t2_ready1", {62'd0, req_ready}, 64'd2);
    tick;
    chk("t2_res1", {32'd0, rsp_result}, 64'd0);
    chk("t2_zc1", {62'd0, rsp_zero, rsp_carry}, 64'd3);
    chk("t2_id1", {63'd0, rsp_id}, 64'd1);
    #1 chk("t2_ready2", {62'd0, req_ready}, 64'd1);
    tick;
    #1 chk("t2_ready3", {62'd0, req_ready}, 64'd2);
    tick;
    req_valid = 2'b00;
    tick;

    // 3: back-pressure freezes the held response and blocks acceptance
    drive0(32'd1, 32'd2, 4'b0100);
    req_valid = 2'b01;
    #1 chk("t3_ready_first", {62'd0, req_ready}, 64'd1);
    tick;
    rsp_ready = 1'b0;
    req_valid = 2'b10;
    drive1(32'h5555_5555, 32'haaaa_aaaa, 4'b0010);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_ready_blocked", {62'd0, req_ready}, 64'd0);
      chk("t3_valid_held", {63'd0, rsp_valid}, 64'd1);
      chk("t3_result_held", {32'd0, rsp_result}, 64'd3);
      chk("t3_id_held", {63'd0, rsp_id}, 64'd0);
      tick;
    end
    rsp_ready = 1'b1;
    #1 chk("t3_ready_release", {62'd0, req_ready}, 64'd2);
    tick;
    req_valid = 2'b00;
    chk("t3_result_new", {32'd0, rsp_result}, 64'd0);
    chk("t3_id_new", {63'd0, rsp_id}, 64'd1);
    tick;

    // 4: one operation per cycle
    t4_a   = '{32'd1, 32'd1, 32'hffff_ffff, 32'h7fff_ffff};
    t4_b   = '{32'd1, 32'd4, 32'd1, 32'hffff_ffff};
    t4_sel = '{4'b1000, 4'b1000, 4'b1100, 4'b1110};
    t4_exp = '{32'd2, 32'h10, 32'd1, 32'd1};
    rsp_ready = 1'b1;
    req_valid = 2'b01;
    for (int i = 0; i < 4; i++) begin
      drive0(t4_a[i], t4_b[i], t4_sel[i]);
      #1 chk("t4_ready", {62'd0, req_ready}, 64'd1);
      tick;
      chk("t4_valid", {63'd0, rsp_valid}, 64'd1);
      chk("t4_result", {32'd0, rsp_result}, {32'd0, t4_exp[i]});
    end
    req_valid = 2'b00;
    tick;

    // 5: asynchronous reset drops a held response; req0 wins first afterwards
    rsp_ready = 1'b0;
    drive0(32'd48, 32'd48, 4'b0000);
    req_valid = 2'b01;
    tick;
    req_valid = 2'b00;
    chk("t5_held", {32'd0, rsp_result}, 64'd96);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_valid", {63'd0, rsp_valid}, 64'd0);
    chk("t5_async_result", {32'd0, rsp_result}, 64'd0);
    tick;
    tick;
    rst = 1'b0;
    rsp_ready = 1'b1;
    drive0(32'h0f0f_0f0f, 32'h00ff_00ff, 4'b0110);
    drive1(32'd3, 32'd5, 4'b0000);
    req_valid = 2'b11;
    #1 chk("t5_first_grant", {62'd0, req_ready}, 64'd1);
    tick;
    req_valid = 2'b00;
    tick;

    // 6: select outside the table
    drive1(32'd5, 32'd7, 4'b0011);
    req_valid = 2'b10;
    #1 chk("t6_ready", {62'd0, req_ready}, 64'd2);
    tick;
    req_valid = 2'b00;
`ifdef ALU_ILLEGAL_CHK_EN
    chk("t6_err", {63'd0, rsp_err}, 64'd1);
`else
    chk("t6_err", {63'd0, rsp_err}, 64'd0);
`endif
    chk("t6_result", {32'd0, rsp_result}, 64'd0);
    chk("t6_zero", {63'd0, rsp_zero}, 64'd1);
    tick;

    waited = 0;
    while (sb_q.size() != 0 && waited < 20) begin
      tick;
      waited++;
    end
    chk("sb_drain", {32'd0, sb_q.size()}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
